// File: rtl/synapse_conductance.sv
// ============================================================================
// Module   : synapse_conductance
// Purpose  : Per-synapse conductance state. Decays gsyn once per tick and adds
//            incoming spike weights with saturation to [0, 2^(W-1)-1].
// Options  : SYNAPSE_CONDUCTANCE_OVERRUN_EN builds the sticky tick_overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module synapse_conductance #(
    parameter int             W          = 16,
    parameter logic [W-1:0]   GSYN_RESET = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [W-1:0]        decay,
    input  logic                spike_valid,
    input  logic signed [W-1:0] spike_weight,
    output logic                spike_ready,
    output logic [W-1:0]        gsyn,
    output logic                gsyn_update,
    output logic                tick_overrun
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DECAY = 1'b1;

    localparam logic signed [W+1:0] c_GMAX = {3'b000, {(W-1){1'b1}}};

    logic [0:0]          r_state;
    logic [W-1:0]        r_gsyn;
    logic [2*W-1:0]      r_prod;
    logic signed [W-1:0] r_pend;
    logic                r_tick_pend;
    logic                r_gsyn_update;

    logic                w_hs;
    logic                w_tick_req;
    logic signed [W+1:0] w_add_sum;
    logic signed [W+1:0] w_dec_sum;

    // W+2 bits hold both the positive overflow and the negative underflow.
    function automatic logic [W-1:0] sat(input logic signed [W+1:0] x);
        if (x < 0)
            sat = '0;
        else if (x > c_GMAX)
            sat = c_GMAX[W-1:0];
        else
            sat = x[W-1:0];
    endfunction

    assign spike_ready = (r_state == S_IDLE);
    assign w_hs        = spike_valid & spike_ready;
    assign w_tick_req  = tick | r_tick_pend;
    assign w_add_sum   = $signed({2'b00, r_gsyn}) + $signed({{2{spike_weight[W-1]}}, spike_weight});
    assign w_dec_sum   = $signed({2'b00, r_prod[2*W-1:W]}) + $signed({{2{r_pend[W-1]}}, r_pend});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_gsyn        <= GSYN_RESET;
            r_prod        <= '0;
            r_pend        <= '0;
            r_tick_pend   <= 1'b0;
            r_gsyn_update <= 1'b0;
        end else begin
            r_gsyn_update <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A decay request wins; a concurrent spike is added after the decay.
                    if (w_tick_req) begin
                        r_prod      <= {{W{1'b0}}, r_gsyn} * {{W{1'b0}}, decay};
                        r_tick_pend <= 1'b0;
                        r_pend      <= w_hs ? spike_weight : '0;
                        r_state     <= S_DECAY;
                    end else if (w_hs) begin
                        r_gsyn <= sat(w_add_sum);
                    end
                end
                S_DECAY: begin
                    r_gsyn        <= sat(w_dec_sum);
                    r_pend        <= '0;
                    r_gsyn_update <= 1'b1;
                    r_state       <= S_IDLE;
                    if (tick)
                        r_tick_pend <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SYNAPSE_CONDUCTANCE_OVERRUN_EN
    logic r_tick_overrun;

    // A tick landing while one is already pending is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_tick_overrun <= 1'b0;
        else if (tick && r_tick_pend)
            r_tick_overrun <= 1'b1;
    end

    assign tick_overrun = r_tick_overrun;
`else
    assign tick_overrun = 1'b0;
`endif

    assign gsyn        = r_gsyn;
    assign gsyn_update = r_gsyn_update;

endmodule

`default_nettype wire

// File: tb/tb_synapse_conductance.sv
// ============================================================================
// Module   : tb_synapse_conductance
// Purpose  : Self-checking bench for synapse_conductance (W=16, GSYN_RESET=100).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_synapse_conductance;

    localparam int W = 16;
`ifdef SYNAPSE_CONDUCTANCE_OVERRUN_EN
    localparam logic OVR = 1'b1;
`else
    localparam logic OVR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         tick;
    logic [W-1:0] decay;
    logic         spike_valid;
    logic [W-1:0] spike_weight;
    logic         spike_ready;
    logic [W-1:0] gsyn;
    logic         gsyn_update;
    logic         tick_overrun;

    synapse_conductance #(.W(W), .GSYN_RESET(16'd100)) dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .decay        (decay),
        .spike_valid  (spike_valid),
        .spike_weight (spike_weight),
        .spike_ready  (spike_ready),
        .gsyn         (gsyn),
        .gsyn_update  (gsyn_update),
        .tick_overrun (tick_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tk;
        logic        sv;
        logic [15:0] w;
        logic [15:0] d;
        logic [15:0] eg;
        logic        er;
        logic        eu;
        logic        eo;
    } vec_t;

    typedef struct {
        logic [15:0] g;
        logic        r;
        logic        u;
        logic        o;
        int          id;
    } exp_t;

    localparam int NV = 27;
    vec_t vecs [NV];
    exp_t sb [$];

    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(input logic tk, input logic sv, input int w, input int d,
                                input int eg, input logic er, input logic eu, input logic eo);
        vec_t v;
        v.tk = tk; v.sv = sv; v.w = 16'(w); v.d = 16'(d);
        v.eg = 16'(eg); v.er = er; v.eu = eu; v.eo = eo;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int eg, input logic er, input logic eu, input logic eo);
        chk({tag, " gsyn"},         int'(gsyn),         eg);
        chk({tag, " spike_ready"},  int'(spike_ready),  int'(er));
        chk({tag, " gsyn_update"},  int'(gsyn_update),  int'(eu));
        chk({tag, " tick_overrun"}, int'(tick_overrun), int'(eo));
    endtask

    initial begin
        exp_t e;
        // Inputs are applied for one cycle; expectations are sampled just after that edge.
        vecs[0]  = mk(0, 1, 900,    16'h8000, 1000,  1, 0, 0);
        vecs[1]  = mk(1, 0, 0,      16'h8000, 1000,  0, 0, 0);
        vecs[2]  = mk(0, 0, 0,      16'h8000, 500,   1, 1, 0);
        vecs[3]  = mk(0, 0, 0,      16'h8000, 500,   1, 0, 0);
        vecs[4]  = mk(0, 1, 31500,  16'h8000, 32000, 1, 0, 0);
        vecs[5]  = mk(0, 1, 2000,   16'h8000, 32767, 1, 0, 0);
        vecs[6]  = mk(0, 1, -32768, 16'h8000, 0,     1, 0, 0);
        vecs[7]  = mk(0, 1, 1000,   16'h8000, 1000,  1, 0, 0);
        vecs[8]  = mk(1, 1, 10,     16'h8000, 1000,  0, 0, 0);
        vecs[9]  = mk(0, 0, 0,      16'h8000, 510,   1, 1, 0);
        vecs[10] = mk(1, 0, 0,      16'hFFFF, 510,   0, 0, 0);
        vecs[11] = mk(0, 1, 100,    16'hFFFF, 509,   1, 1, 0);
        vecs[12] = mk(0, 1, -600,   16'hFFFF, 0,     1, 0, 0);
        vecs[13] = mk(0, 1, 32767,  16'h0000, 32767, 1, 0, 0);
        vecs[14] = mk(1, 0, 0,      16'h0000, 32767, 0, 0, 0);
        vecs[15] = mk(0, 0, 0,      16'h0000, 0,     1, 1, 0);
        vecs[16] = mk(0, 1, 1000,   16'h8000, 1000,  1, 0, 0);
        vecs[17] = mk(1, 0, 0,      16'h8000, 1000,  0, 0, 0);
        vecs[18] = mk(1, 0, 0,      16'h8000, 500,   1, 1, 0);
        vecs[19] = mk(1, 0, 0,      16'h8000, 500,   0, 0, OVR);
        vecs[20] = mk(0, 0, 0,      16'h8000, 250,   1, 1, OVR);
        vecs[21] = mk(0, 0, 0,      16'h8000, 250,   1, 0, OVR);
        vecs[22] = mk(1, 0, 0,      16'h8000, 250,   0, 0, OVR);
        vecs[23] = mk(1, 0, 0,      16'h8000, 125,   1, 1, OVR);
        vecs[24] = mk(0, 0, 0,      16'h8000, 125,   0, 0, OVR);
        vecs[25] = mk(0, 0, 0,      16'h8000, 62,    1, 1, OVR);
        vecs[26] = mk(0, 0, 0,      16'h8000, 62,    1, 0, OVR);

        reset = 1'b1; tick = 1'b0; decay = '0; spike_valid = 1'b0; spike_weight = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all("reset", 100, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            tick = vecs[i].tk; spike_valid = vecs[i].sv;
            spike_weight = vecs[i].w; decay = vecs[i].d;
            e.g = vecs[i].eg; e.r = vecs[i].er; e.u = vecs[i].eu; e.o = vecs[i].eo; e.id = i;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("scoreboard empty", 0, 1);
            end else begin
                e = sb.pop_front();
                chk_all($sformatf("vec%0d", e.id), int'(e.g), e.r, e.u, e.o);
            end
        end

        // Reset asserted while in DECAY discards the pending decay.
        @(negedge clk);
        tick = 1'b1; spike_valid = 1'b0; decay = 16'h8000;
        @(posedge clk);
        #1;
        tick = 1'b0;
        chk("rst_mid in DECAY spike_ready", int'(spike_ready), 0);
        #2 reset = 1'b1;
        #1;
        chk_all("rst_mid async", 100, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk_all($sformatf("rst_mid after%0d", k), 100, 1'b1, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
